toggle_period_mon_multi: RTL and testbench
==========================================

Name: toggle_period_mon_multi

Overview:
- Multi-channel successor to the single-channel toggle period meter. Measures the period of N_CH asynchronous toggle inputs in pix_clk cycles.
- Adds per-channel timeout/stale detection, min/max tracking, overrun flagging, and a round-robin valid/ready result stream.
- Sits in the pix_clk domain and feeds the logger/pager. Typical inputs are field/line toggles from camera-side domains.

Parameters:
- N_CH, 4: number of toggle channels (1..16).
- CNT_W, 24: period counter and result width.
- SYNC_STAGES, 3: synchroniser depth per channel (>=2).
- TIMEOUT, 24'd2000000: cycles without an edge before a channel goes stale (1 < TIMEOUT <= 2^CNT_W-1).
- AVG_LOG2, 3: smoothing shift for the optional average (1..8).

Ports:
- pix_clk  in  1  sole clock.
- pix_rst  in  1  synchronous reset, active-high.
- tog_in  in  N_CH  asynchronous toggle inputs; each level change is one event.
- clr_minmax  in  1  one-cycle pulse; re-initialises min/max of all channels.
- stale  out  N_CH  per-channel timeout flag.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result when out_valid && out_ready.
- out_ch  out  $clog2(N_CH) (min 1)  channel of the result.
- out_period  out  CNT_W  measured period in cycles.
- out_min  out  CNT_W  channel minimum, including this result.
- out_max  out  CNT_W  channel maximum, including this result.
- out_ovr  out  1  an earlier result from this channel was overwritten before being sent.
- out_avg  out  CNT_W  smoothed period (optional feature).

Behaviour:
- Reset values: every output 0. Per-channel sync chains, counters, armed, pending and overrun flags are 0. min = all-ones, max = 0. Round-robin pointer = 0.
- Reset is synchronous and takes effect at any point, including mid-handshake: out_valid drops the cycle after pix_rst is sampled high.
- Synchroniser: a SYNC_STAGES flop chain per channel. edge = XOR of the last two stages, giving one cycle per level change.
- Counter, per channel:
  - On edge: cnt <= 1.
  - Otherwise: cnt <= cnt + 1 while cnt < TIMEOUT; it holds at TIMEOUT.
  - The cnt value sampled on an edge is the exact period in cycles.
- Armed, per channel:
  - The first edge after reset only sets armed and produces no result.
  - The same applies to the first edge after a stale period.
- Stale, per channel:
  - stale is set on the cycle cnt reaches TIMEOUT while armed.
  - The next edge clears stale, discards that measurement, and sets cnt <= 1.
- Result generation:
  - On an edge while armed and not stale, period p is computed.
  - min <= min(min, p); max <= max(max, p).
  - The holding register is loaded with {p, new min, new max}, and pending is set.
  - If pending was already set and the old holding value was not consumed that cycle: overwrite it and set ovr.
- clr_minmax:
  - Without a coincident result: min = all-ones, max = 0.
  - With a coincident result p on a channel: that channel gets min = max = p.
- Output register, one deep:
  - Loaded when it is empty or an accept occurs that cycle.
  - Source is the first pending channel at or after the pointer, wrapping.
  - On load: pending and ovr of that channel clear, out_ovr = ovr, pointer <= granted + 1 (mod N_CH).
- Handshake: out_valid, once set, holds with all out_* stable until accepted. Back-to-back accepts give one result per cycle.
- Same cycle, new result into a holding register being drained: the new value wins, pending stays 1, no ovr.
- Latency: a tog_in change reaches the edge SYNC_STAGES cycles after first capture. The holding register is written on that edge, and out_valid rises on the next cycle when the output register is empty.

Optional Feature:
- Macro: TOGGLE_PERIOD_MON_AVG_EN.
- Defined:
  - Per-channel running average; the first result after reset or stale sets avg = p.
  - Thereafter avg <= avg + ((p - avg) >>> AVG_LOG2), computed signed in CNT_W+1 bits and truncated to CNT_W.
  - The value is snapshotted into out_avg alongside the other result fields.
- Undefined: no average registers; out_avg tied to 0.

Test Plan:
- Test instance: N_CH=4, CNT_W=16, TIMEOUT=1000, SYNC_STAGES=3, out_ready=1.
- Steady period: tog_in[0] toggles every 100 cycles -> no output for the first edge, then each result reads ch=0, period=100, min=max=100, ovr=0.
- Timeout: tog_in[1] toggles twice (period 300), then is idle -> stale[1]=1 exactly 1000 cycles after the last edge. The next toggle gives no output and stale[1]=0. A toggle 50 cycles later gives period=50, min=50, max=300.
- Backpressure/overrun: out_ready=0, ch2 periods 40, 60, 80 -> output held at 40. Then release ready -> 40 (ovr=0), followed by 80 (ovr=1); 60 never appears.
- Round-robin: edges on all 4 channels in the same cycle -> results in order ch0, ch1, ch2, ch3 on consecutive cycles. A later simultaneous ch0+ch3 event after a ch1 grant -> ch3 first, then ch0.
- clr_minmax: ch0 history min=50, max=200; clr_minmax coincides with a period of 70 -> result min=max=70. A following period of 90 -> min=70, max=90.
- Reset mid-operation: pix_rst high for 1 cycle while out_valid=1 and out_ready=0 -> out_valid=0 and stale=0 next cycle. The first edge afterwards produces no output.

Source files
------------

// File: rtl/toggle_period_mon_multi.sv
// Multi-channel toggle period monitor: per-channel period, min/max, stale and overrun, round-robin result stream.
// Optional smoothed average enabled by defining TOGGLE_PERIOD_MON_AVG_EN.
module toggle_period_mon_multi #(
  parameter int unsigned N_CH        = 4,
  parameter int unsigned CNT_W       = 24,
  parameter int unsigned SYNC_STAGES = 3,
  parameter int unsigned TIMEOUT     = 2000000,
  parameter int unsigned AVG_LOG2    = 3,
  localparam int unsigned CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic              pix_clk,
  input  logic              pix_rst,
  input  logic [N_CH-1:0]   tog_in,
  input  logic              clr_minmax,
  output logic [N_CH-1:0]   stale,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CH_W-1:0]   out_ch,
  output logic [CNT_W-1:0]  out_period,
  output logic [CNT_W-1:0]  out_min,
  output logic [CNT_W-1:0]  out_max,
  output logic              out_ovr,
  output logic [CNT_W-1:0]  out_avg
);

  localparam logic [CNT_W-1:0] TO = CNT_W'(TIMEOUT);

  if (N_CH < 1 || N_CH > 16) begin : g_bad_nch
    $error("N_CH must be 1..16");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end
  if (AVG_LOG2 < 1 || AVG_LOG2 > 8) begin : g_bad_avg
    $error("AVG_LOG2 must be 1..8");
  end

  logic [SYNC_STAGES-1:0] r_sync [N_CH];
  logic [CNT_W-1:0]       r_cnt  [N_CH];
  logic [CNT_W-1:0]       r_min  [N_CH];
  logic [CNT_W-1:0]       r_max  [N_CH];
  logic [CNT_W-1:0]       r_hp   [N_CH];
  logic [CNT_W-1:0]       r_hmin [N_CH];
  logic [CNT_W-1:0]       r_hmax [N_CH];
  logic [N_CH-1:0]        r_armed, r_stale, r_pend, r_ovr;

  logic [N_CH-1:0]        w_edge, w_res, w_drain;
  logic [CNT_W-1:0]       w_nmin [N_CH];
  logic [CNT_W-1:0]       w_nmax [N_CH];

  logic                   r_valid, r_out_ovr;
  logic [CH_W-1:0]        r_out_ch, r_ptr;
  logic [CNT_W-1:0]       r_out_p, r_out_min, r_out_max;

  logic                   w_load, w_gnt_any, w_take;
  logic [CH_W-1:0]        w_gnt;

  always_comb begin
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_edge[c] = r_sync[c][SYNC_STAGES-1] ^ r_sync[c][SYNC_STAGES-2];
      w_res[c]  = w_edge[c] & r_armed[c] & ~r_stale[c];
      w_nmin[c] = r_min[c];
      w_nmax[c] = r_max[c];
      // A coincident clear restarts the history from this result alone.
      if (clr_minmax) begin
        w_nmin[c] = w_res[c] ? r_cnt[c] : '1;
        w_nmax[c] = w_res[c] ? r_cnt[c] : '0;
      end else if (w_res[c]) begin
        w_nmin[c] = (r_cnt[c] < r_min[c]) ? r_cnt[c] : r_min[c];
        w_nmax[c] = (r_cnt[c] > r_max[c]) ? r_cnt[c] : r_max[c];
      end
    end
  end

  always_comb begin
    int unsigned idx;
    idx       = 0;
    w_gnt_any = 1'b0;
    w_gnt     = '0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(r_ptr) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!w_gnt_any && r_pend[CH_W'(idx)]) begin
        w_gnt_any = 1'b1;
        w_gnt     = CH_W'(idx);
      end
    end
    w_load  = ~r_valid | out_ready;
    w_take  = w_load & w_gnt_any;
    w_drain = '0;
    if (w_take) w_drain[w_gnt] = 1'b1;
  end

`ifdef TOGGLE_PERIOD_MON_AVG_EN
  logic [CNT_W-1:0]        r_avg  [N_CH];
  logic [CNT_W-1:0]        r_havg [N_CH];
  logic [CNT_W-1:0]        w_navg [N_CH];
  logic [N_CH-1:0]         r_avg_ok;
  logic [CNT_W-1:0]        r_out_avg;
  logic signed [CNT_W:0]   w_diff;

  always_comb begin
    w_diff = '0;
    for (int unsigned c = 0; c < N_CH; c++) begin
      w_diff    = $signed({1'b0, r_cnt[c]}) - $signed({1'b0, r_avg[c]});
      w_navg[c] = r_avg_ok[c]
                ? CNT_W'($signed({1'b0, r_avg[c]}) + (w_diff >>> AVG_LOG2))
                : r_cnt[c];
    end
  end

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      r_avg_ok  <= '0;
      r_out_avg <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_avg[c]  <= '0;
        r_havg[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        if (w_res[c]) begin
          r_avg[c]    <= w_navg[c];
          r_havg[c]   <= w_navg[c];
          r_avg_ok[c] <= 1'b1;
        end else if (!w_edge[c] && r_armed[c] && r_cnt[c] == TO - 1'b1) begin
          r_avg_ok[c] <= 1'b0;
        end
      end
      if (w_take) r_out_avg <= r_havg[w_gnt];
    end
  end

  assign out_avg = r_out_avg;
`else
  assign out_avg = '0;
`endif

  always_ff @(posedge pix_clk) begin
    if (pix_rst) begin
      r_armed   <= '0;
      r_stale   <= '0;
      r_pend    <= '0;
      r_ovr     <= '0;
      r_valid   <= 1'b0;
      r_out_ovr <= 1'b0;
      r_out_ch  <= '0;
      r_ptr     <= '0;
      r_out_p   <= '0;
      r_out_min <= '0;
      r_out_max <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_sync[c] <= '0;
        r_cnt[c]  <= '0;
        r_min[c]  <= '1;
        r_max[c]  <= '0;
        r_hp[c]   <= '0;
        r_hmin[c] <= '0;
        r_hmax[c] <= '0;
      end
    end else begin
      for (int unsigned c = 0; c < N_CH; c++) begin
        r_sync[c] <= {r_sync[c][SYNC_STAGES-2:0], tog_in[c]};
        if (w_edge[c])         r_cnt[c] <= CNT_W'(1);
        else if (r_cnt[c] < TO) r_cnt[c] <= r_cnt[c] + 1'b1;

        if (w_edge[c]) begin
          r_armed[c] <= 1'b1;
          r_stale[c] <= 1'b0;
        end else if (r_armed[c] && r_cnt[c] == TO - 1'b1) begin
          r_stale[c] <= 1'b1;
        end

        r_min[c] <= w_nmin[c];
        r_max[c] <= w_nmax[c];

        // A result landing on a holding register being drained replaces it without overrun.
        if (w_res[c]) begin
          r_hp[c]   <= r_cnt[c];
          r_hmin[c] <= w_nmin[c];
          r_hmax[c] <= w_nmax[c];
          r_pend[c] <= 1'b1;
          if (r_pend[c] && !w_drain[c]) r_ovr[c] <= 1'b1;
          else if (w_drain[c])          r_ovr[c] <= 1'b0;
        end else if (w_drain[c]) begin
          r_pend[c] <= 1'b0;
          r_ovr[c]  <= 1'b0;
        end
      end

      if (w_load) begin
        r_valid <= w_gnt_any;
        if (w_gnt_any) begin
          r_out_ch  <= w_gnt;
          r_out_p   <= r_hp[w_gnt];
          r_out_min <= r_hmin[w_gnt];
          r_out_max <= r_hmax[w_gnt];
          r_out_ovr <= r_ovr[w_gnt];
          r_ptr     <= (32'(w_gnt) >= N_CH - 1) ? '0 : w_gnt + 1'b1;
        end
      end
    end
  end

  assign stale      = r_stale;
  assign out_valid  = r_valid;
  assign out_ch     = r_out_ch;
  assign out_period = r_out_p;
  assign out_min    = r_out_min;
  assign out_max    = r_out_max;
  assign out_ovr    = r_out_ovr;

endmodule

// File: tb/tb_toggle_period_mon_multi.sv
// Directed bench for toggle_period_mon_multi: table-driven period vectors plus hand-written stream sequences.
module tb_toggle_period_mon_multi;

  logic        pix_clk, pix_rst, clr_minmax, out_valid, out_ready, out_ovr;
  logic [3:0]  tog_in, stale;
  logic [1:0]  out_ch;
  logic [15:0] out_period, out_min, out_max, out_avg;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  toggle_period_mon_multi #(
    .N_CH(4), .CNT_W(16), .SYNC_STAGES(3), .TIMEOUT(1000), .AVG_LOG2(3)
  ) dut (
    .pix_clk(pix_clk), .pix_rst(pix_rst), .tog_in(tog_in), .clr_minmax(clr_minmax),
    .stale(stale), .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch),
    .out_period(out_period), .out_min(out_min), .out_max(out_max),
    .out_ovr(out_ovr), .out_avg(out_avg)
  );

  initial pix_clk = 1'b0;
  always #5 pix_clk = ~pix_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [3:0]  mask;
    int unsigned wt;
    logic        clr;
    logic        exp_v;
    logic [1:0]  ch;
    logic [15:0] per, mn, mx;
    logic        ovr;
    logic [3:0]  stl;
  } vec_t;

  vec_t tv [0:12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    pix_rst    = 1'b1;
    tog_in     = '0;
    clr_minmax = 1'b0;
    repeat (4) @(posedge pix_clk);
    #1 pix_rst = 1'b0;
    @(negedge pix_clk);
  endtask

  // Flip after wt posedges; the edge is sampled 3 posedges later, the result is visible after the 4th.
  task automatic flip(input logic [3:0] m, input logic c, input int unsigned wt);
    repeat (wt) @(posedge pix_clk);
    #1 tog_in = tog_in ^ m;
    @(posedge pix_clk);
    @(posedge pix_clk);
    #1 if (c) clr_minmax = 1'b1;
    @(posedge pix_clk);
    #1 clr_minmax = 1'b0;
    @(posedge pix_clk);
    @(negedge pix_clk);
  endtask

  task automatic chk_out(input string nm, input logic [1:0] ch, input logic [15:0] p,
                         input logic [15:0] mn, input logic [15:0] mx, input logic ovr);
    chk({nm, ".valid"}, 32'(out_valid), 32'd1);
    chk({nm, ".ch"},    32'(out_ch),    32'(ch));
    chk({nm, ".per"},   32'(out_period), 32'(p));
    chk({nm, ".min"},   32'(out_min),   32'(mn));
    chk({nm, ".max"},   32'(out_max),   32'(mx));
    chk({nm, ".ovr"},   32'(out_ovr),   32'(ovr));
  endtask

  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      flip(tv[i].mask, tv[i].clr, tv[i].wt);
      chk($sformatf("vec%0d.stale", i), 32'(stale), 32'(tv[i].stl));
      if (tv[i].exp_v)
        chk_out($sformatf("vec%0d", i), tv[i].ch, tv[i].per, tv[i].mn, tv[i].mx, tv[i].ovr);
      else
        chk($sformatf("vec%0d.valid", i), 32'(out_valid), 32'd0);
`ifndef TOGGLE_PERIOD_MON_AVG_EN
      chk($sformatf("vec%0d.avg", i), 32'(out_avg), 32'd0);
`endif
    end
  endtask

  initial begin
    // wt = period - 4 when a vector follows directly on the previous one's check point.
    tv[0]  = '{4'b0001, 10,     1'b0, 1'b0, 2'd0, 16'd0,   16'd0,   16'd0,   1'b0, 4'b0000};
    tv[1]  = '{4'b0001, 100-4,  1'b0, 1'b1, 2'd0, 16'd100, 16'd100, 16'd100, 1'b0, 4'b0000};
    tv[2]  = '{4'b0001, 100-4,  1'b0, 1'b1, 2'd0, 16'd100, 16'd100, 16'd100, 1'b0, 4'b0000};
    tv[3]  = '{4'b0001, 100-4,  1'b0, 1'b1, 2'd0, 16'd100, 16'd100, 16'd100, 1'b0, 4'b0000};
    tv[4]  = '{4'b0010, 10,     1'b0, 1'b0, 2'd0, 16'd0,   16'd0,   16'd0,   1'b0, 4'b0000};
    tv[5]  = '{4'b0010, 300-4,  1'b0, 1'b1, 2'd1, 16'd300, 16'd300, 16'd300, 1'b0, 4'b0000};
    tv[6]  = '{4'b0010, 20,     1'b0, 1'b0, 2'd0, 16'd0,   16'd0,   16'd0,   1'b0, 4'b0000};
    tv[7]  = '{4'b0010, 50-4,   1'b0, 1'b1, 2'd1, 16'd50,  16'd50,  16'd300, 1'b0, 4'b0000};
    tv[8]  = '{4'b0001, 10,     1'b0, 1'b0, 2'd0, 16'd0,   16'd0,   16'd0,   1'b0, 4'b0000};
    tv[9]  = '{4'b0001, 50-4,   1'b0, 1'b1, 2'd0, 16'd50,  16'd50,  16'd50,  1'b0, 4'b0000};
    tv[10] = '{4'b0001, 200-4,  1'b0, 1'b1, 2'd0, 16'd200, 16'd50,  16'd200, 1'b0, 4'b0000};
    tv[11] = '{4'b0001, 70-4,   1'b1, 1'b1, 2'd0, 16'd70,  16'd70,  16'd70,  1'b0, 4'b0000};
    tv[12] = '{4'b0001, 90-4,   1'b0, 1'b1, 2'd0, 16'd90,  16'd70,  16'd90,  1'b0, 4'b0000};

    out_ready = 1'b1;
    do_reset();
    chk("rst.valid",  32'(out_valid),  32'd0);
    chk("rst.stale",  32'(stale),      32'd0);
    chk("rst.ch",     32'(out_ch),     32'd0);
    chk("rst.per",    32'(out_period), 32'd0);
    chk("rst.min",    32'(out_min),    32'd0);
    chk("rst.max",    32'(out_max),    32'd0);
    chk("rst.ovr",    32'(out_ovr),    32'd0);
    chk("rst.avg",    32'(out_avg),    32'd0);

    // Steady period on ch0.
    run_vecs(0, 3);

    // Timeout on ch1: stale rises when the counter reaches 1000 after the last edge.
    do_reset();
    run_vecs(4, 5);
    repeat (997) @(posedge pix_clk);
    @(negedge pix_clk);
    chk("stale.early", 32'(stale), 32'b0000);
    @(negedge pix_clk);
    chk("stale.set",   32'(stale), 32'b0010);
    run_vecs(6, 7);

    // clr_minmax coinciding with a result.
    do_reset();
    run_vecs(8, 12);

    // Backpressure and overrun on ch2.
    do_reset();
    flip(4'b0100, 1'b0, 10);
    out_ready = 1'b0;
    flip(4'b0100, 1'b0, 40-4);
    chk_out("bp.first", 2'd2, 16'd40, 16'd40, 16'd40, 1'b0);
    flip(4'b0100, 1'b0, 60-4);
    chk_out("bp.hold60", 2'd2, 16'd40, 16'd40, 16'd40, 1'b0);
    flip(4'b0100, 1'b0, 80-4);
    chk_out("bp.hold80", 2'd2, 16'd40, 16'd40, 16'd40, 1'b0);
    out_ready = 1'b1;
    @(negedge pix_clk);
    chk_out("bp.ovr", 2'd2, 16'd80, 16'd40, 16'd80, 1'b1);
    @(negedge pix_clk);
    chk("bp.empty", 32'(out_valid), 32'd0);

    // Round-robin ordering.
    do_reset();
    flip(4'b1111, 1'b0, 10);
    chk("rr.arm", 32'(out_valid), 32'd0);
    flip(4'b1111, 1'b0, 24-4);
    chk_out("rr.c0", 2'd0, 16'd24, 16'd24, 16'd24, 1'b0);
    for (int k = 1; k < 4; k++) begin
      @(negedge pix_clk);
      chk_out($sformatf("rr.c%0d", k), 2'(k), 16'd24, 16'd24, 16'd24, 1'b0);
    end
    @(negedge pix_clk);
    chk("rr.empty", 32'(out_valid), 32'd0);
    flip(4'b0010, 1'b0, 10);
    chk("rr.g1.valid", 32'(out_valid), 32'd1);
    chk("rr.g1.ch",    32'(out_ch),    32'd1);
    flip(4'b1001, 1'b0, 10);
    chk("rr.g3.valid", 32'(out_valid), 32'd1);
    chk("rr.g3.ch",    32'(out_ch),    32'd3);
    @(negedge pix_clk);
    chk("rr.g0.valid", 32'(out_valid), 32'd1);
    chk("rr.g0.ch",    32'(out_ch),    32'd0);
    @(negedge pix_clk);
    chk("rr.g.empty",  32'(out_valid), 32'd0);

    // Reset in the middle of a held handshake.
    do_reset();
    out_ready = 1'b0;
    flip(4'b0001, 1'b0, 10);
    flip(4'b0001, 1'b0, 20);
    chk("mrst.pre", 32'(out_valid), 32'd1);
    pix_rst = 1'b1;
    @(posedge pix_clk);
    #1 pix_rst = 1'b0;
    @(negedge pix_clk);
    chk("mrst.valid", 32'(out_valid),  32'd0);
    chk("mrst.stale", 32'(stale),      32'd0);
    chk("mrst.per",   32'(out_period), 32'd0);
    out_ready = 1'b1;
    flip(4'b0001, 1'b0, 10);
    chk("mrst.arm", 32'(out_valid), 32'd0);
    flip(4'b0001, 1'b0, 30-4);
    chk_out("mrst.res", 2'd0, 16'd30, 16'd30, 16'd30, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
